uart_rx: RTL and testbench
==========================

# uart_rx

Serial UART receiver that converts an 8N1 bitstream on a single input line back into bytes. It is the receive-direction counterpart of the existing `UART_tx` and uses the same `CLKS_PER_BIT` timing convention. It feeds the register file's `uart_rx_data` and `busy` inputs so software can read received bytes. It samples the line at mid-bit, validates the start and stop bits, and flags framing errors.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per serial bit. Must be ≥ 4.
- `WIDTH`, default 8: data bits per frame. Fixed at 8 for this revision.
- `clk`  in  1: single clock for the whole block.
- `rst_n`  in  1: reset, synchronous and active-low.
- `rx_en`  in  1: enables start-bit detection. Sampled only in IDLE.
- `serial_data_in`  in  1: asynchronous serial line. Idle level is high.
- `data_out`  out  WIDTH: last correctly framed byte, LSB received first.
- `done`  out  1: one-cycle pulse at the end of every frame (good or bad).
- `frame_err`  out  1: status of the last completed frame. 1 means the stop bit was sampled low.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- **Input synchronizer:** `serial_data_in` passes through a 2-flop synchronizer to give `rx_s`. Only `rx_s` is used internally.
- **Counters:**
  - `clk_cnt`: $clog2(CLKS_PER_BIT) bits, cleared on every state change.
  - `bit_idx`: 3 bits.
- **IDLE**
  - If `rx_en`=1 and `rx_s`=0, go to START.
- **START**
  - Wait until `clk_cnt` = (CLKS_PER_BIT-1)/2, integer divide.
  - If `rx_s`=0 there, go to DATA with `bit_idx`=0.
  - Otherwise treat it as a glitch and return to IDLE. No `done` is issued.
- **DATA**
  - At `clk_cnt` = CLKS_PER_BIT-1, write `rx_s` into shift register bit `bit_idx`.
  - If `bit_idx`=7, go to STOP; otherwise increment `bit_idx`.
- **STOP**
  - At `clk_cnt` = CLKS_PER_BIT-1, sample `rx_s`.
  - If 1: load the shift register into `data_out`, clear `frame_err`, pulse `done`, go to IDLE.
  - If 0: set `frame_err`, pulse `done`, leave `data_out` unchanged, go to BREAK.
- **BREAK**
  - Wait for `rx_s`=1, then go to IDLE.
  - This prevents a held-low line (break) from retriggering reception.
- **`rx_en` behaviour:** deasserting `rx_en` mid-frame does not abort the frame. It only blocks the next start detection.
- **`frame_err`:** holds its value until the next `done`.
- **`busy`:** equals (state != IDLE), decoded from registered state.

## Timing
- **Reset** (`rst_n`=0 at a `clk` edge):
  - state = IDLE.
  - `data_out` = 0, `done` = 0, `frame_err` = 0, `busy` = 0.
  - Both synchronizer flops = 1.
  - Counters = 0.
  - Reset mid-frame discards the partial byte. No `done` is produced.
- **Sample points:** in DATA and STOP, sampling occurs every CLKS_PER_BIT cycles, aligned to the start-bit midpoint.
- **Detection latency:** synchronizer adds 2 cycles; the IDLE→START decision adds 1.
- **Frame latency:** `done` rises 9·CLKS_PER_BIT + (CLKS_PER_BIT-1)/2 + 4 cycles after the line's falling edge, ±1 cycle.
  - `done` is high for exactly 1 cycle.
  - `data_out` and `frame_err` are valid in the same cycle as `done` and stable afterwards.
- **Back-to-back frames:** IDLE is re-entered at mid-stop-bit. A start bit immediately following the stop bit is detected with no lost frame.
- **Clock tolerance:** ±2% clock mismatch between transmitter and receiver must still decode correctly.

## Test plan
Benches use CLKS_PER_BIT=16 and drive `serial_data_in` from a behavioural transmitter or from `UART_tx` in loopback.

- **Single byte:** `rx_en`=1, send 0xA5 (8N1) → one `done` pulse; `data_out`=0xA5, `frame_err`=0; `busy` high from 3 cycles after the start edge until `done`.
- **Back-to-back:** send 0x00, 0xFF, 0x3C with no idle gap → three `done` pulses with `data_out` = 0x00, 0xFF, 0x3C in order, each with `frame_err`=0.
- **Start glitch:** drive the line low for 4 cycles, then high → no `done`; `busy` returns to 0 at most 12 cycles after the glitch; `data_out` unchanged.
- **Framing error and break:**
  - Receive 0x5A correctly.
  - Send 0x3C with the stop bit low and hold the line low for 40 cycles → `done` pulses with `frame_err`=1 and `data_out` still 0x5A; `busy` stays 1 while the line stays low.
  - Release the line, then send 0x81 → `data_out`=0x81, `frame_err`=0.
- **Enable gating:** `rx_en`=0 while sending 0x77 → no `done`, `busy`=0 throughout. Set `rx_en`=1 mid-frame of a second 0x77 → no false byte is accepted before the next clean start.
- **Reset mid-frame:** assert `rst_n`=0 for 2 cycles during bit 4 of 0xC3 → all outputs 0; line idles; subsequent 0x12 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, framing-error flag and break hold-off.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int WIDTH        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_en,
    input  logic             serial_data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             done,
    output logic             frame_err,
    output logic             busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;
    logic             meta_q, meta_d;
    logic             rx_s_q, rx_s_d;

    always_comb begin
        meta_d    = serial_data_in;
        rx_s_d    = meta_q;
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + CW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        ferr_d    = ferr_q;

        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                if (rx_en && !rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (clk_cnt_q == HALF_CNT) begin
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                // Counter wraps every bit so samples stay aligned to the start-bit midpoint.
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (clk_cnt_q == LAST_CNT) begin
                    done_d = 1'b1;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        ferr_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                clk_cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            clk_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            meta_q    <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            meta_q    <= meta_d;
            rx_s_q    <= rx_s_d;
        end
    end

    assign data_out  = data_q;
    assign done      = done_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx driven by a behavioural 8N1 transmitter.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_en;
    logic       line;
    logic [7:0] data_out;
    logic       done;
    logic       frame_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .WIDTH(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_en          (rx_en),
        .serial_data_in (line),
        .data_out       (data_out),
        .done           (done),
        .frame_err      (frame_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
    } exp_t;

    exp_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         done_cnt = 0;
    int         last_done_cyc = 0;
    int         busy_rise_cyc = 0;
    int         start_cyc = 0;
    logic       busy_seen = 1'b0;
    logic       busy_prev = 1'b0;
    logic       done_prev = 1'b0;
    logic [7:0] last_good = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        line = v;
        tick(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        start_cyc = cyc;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
        drive_bit(stop_v, CPB);
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_q.push_back('{d: b, fe: 1'b0});
        last_good = b;
        send_frame(b, 1'b1);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && busy && !busy_prev) busy_rise_cyc = cyc;
            if (busy) busy_seen = 1'b1;
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
                chk("done_width", 32'(done_prev), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done_queue_size", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out", 32'(data_out), 32'(e.d));
                    chk("frame_err", 32'(frame_err), 32'(e.fe));
                end
            end
            busy_prev = busy;
            done_prev = done;
        end
    endtask

    initial begin
        int d0;
        logic [7:0] b;
        fork
            monitor();
            begin
                #1_000_000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        rst_n = 1'b0;
        rx_en = 1'b1;
        line  = 1'b1;
        tick(3);
        chk("reset_data_out", 32'(data_out), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(5);

        // Single byte with latency checks
        send_good(8'hA5);
        chk("busy_rise_latency", 32'(busy_rise_cyc - start_cyc), 32'd3);
        chk("done_latency_window",
            32'((last_done_cyc - start_cyc >= 154) && (last_done_cyc - start_cyc <= 156)), 32'd1);
        tick(10);

        // Back-to-back frames
        send_good(8'h00);
        send_good(8'hFF);
        send_good(8'h3C);
        tick(10);

        // Start glitch
        d0 = done_cnt;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 12);
        chk("glitch_busy_cleared", 32'(busy), 32'd0);
        tick(20);
        chk("glitch_no_done", 32'(done_cnt), 32'(d0));
        chk("glitch_data_kept", 32'(data_out), 32'(last_good));

        // Framing error followed by a held-low break
        send_good(8'h5A);
        exp_q.push_back('{d: last_good, fe: 1'b1});
        send_frame(8'h3C, 1'b0);
        drive_bit(1'b0, 40);
        chk("break_busy_held", 32'(busy), 32'd1);
        drive_bit(1'b1, CPB);
        chk("break_released_idle", 32'(busy), 32'd0);
        send_good(8'h81);
        tick(10);

        // Enable gating
        rx_en = 1'b0;
        busy_seen = 1'b0;
        d0 = done_cnt;
        send_frame(8'h77, 1'b1);
        chk("disabled_never_busy", 32'(busy_seen), 32'd0);
        chk("disabled_no_done", 32'(done_cnt), 32'(d0));
        b = 8'h77;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
        drive_bit(1'b1, CPB / 2);
        rx_en = 1'b1;
        drive_bit(1'b1, CPB / 2 + 8);
        chk("late_enable_no_false_byte", 32'(done_cnt), 32'(d0));
        send_good(8'h77);
        tick(10);

        // Reset during bit 4 of 0xC3
        d0 = done_cnt;
        b = 8'hC3;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(b[i], CPB);
        drive_bit(b[4], CPB / 2);
        rst_n = 1'b0;
        tick(2);
        chk("midreset_data_out", 32'(data_out), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_frame_err", 32'(frame_err), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        line  = 1'b1;
        last_good = 8'h00;
        tick(20);
        chk("midreset_no_done", 32'(done_cnt), 32'(d0));
        send_good(8'h12);

        // Randomized bytes with random idle gaps
        for (int k = 0; k < 16; k++) begin
            drive_bit(1'b1, int'($urandom_range(0, 20)));
            send_good(8'($urandom_range(0, 255)));
        end

        tick(40);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
